uart_rx_param: RTL
==================

# uart_rx_param

Parametrised, fully synchronous UART receive engine for the serial-link subsystem. It decodes asynchronous frames from `Rx` using a single-cycle oversampling strobe (`Tick`) supplied by the shared baud generator. Per frame it supports a runtime-selectable data length, optional even/odd parity, and majority-vote bit sampling. Received words go out through a ready/valid handshake with frame, parity and overrun status.

## Interface
- `DW`, 8: maximum data bits per frame; RxData width (5..9).
- `OVERSAMPLE`, 16: Tick pulses per bit period (even, 8..32).
- `Clk` input 1: sole clock; all state changes on rising edge.
- `Rst_n` input 1: asynchronous, active-low reset; one clock domain.
- `RxEn` input 1: receive enable; low forces IDLE.
- `Tick` input 1: one-Clk-wide oversampling strobe, OVERSAMPLE per bit.
- `Rx` input 1: asynchronous serial line, idle high.
- `NBits` input 4: data bits this frame (5..DW); out-of-range values are treated as DW.
- `ParityEn` input 1: 1 = a parity bit follows the data.
- `ParityOdd` input 1: 1 = odd parity, 0 = even (used only with ParityEn).
- `RxData` output DW: received word, LSB first on line, right-aligned, upper bits zero.
- `RxValid` output 1: RxData and status flags valid.
- `RxReady` input 1: consumer accepts the word when RxValid & RxReady.
- `FrameErr` output 1: stop bit sampled 0 for the held word.
- `ParityErr` output 1: parity mismatch for the held word.
- `Overrun` output 1: a frame was dropped because the held word was not taken.
- `Busy` output 1: FSM not in IDLE.

## Operation
- `Rx` passes through a 2-flop synchroniser reset to 1. All decoding uses the synchronised value `rxs`.
- Bit-phase counter `cnt` (log2(OVERSAMPLE) bits) advances only on Tick and wraps at OVERSAMPLE-1.
- Sample point: majority of `rxs` at Ticks with cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit is decided at the third sample.
- FSM states are IDLE, START, DATA, PARITY, STOP:
  - IDLE→START: RxEn=1 and falling edge on rxs (previous 1, current 0). cnt cleared.
  - START: if the majority vote is 1, it is a false start and returns to IDLE with no output. If 0, go to DATA when cnt wraps.
  - DATA: shift the voted bit into a DW-bit shift register (right shift, MSB in). Bit index counts 0..NBits-1. After the last bit go to PARITY if ParityEn=1, else to STOP.
  - PARITY: voted bit XOR data parity is compared against ParityOdd, and the mismatch result is latched. Go to STOP.
  - STOP: at the vote, load the output holding register and go directly to IDLE. The FSM does not wait for the end of the stop bit, so back-to-back frames are accepted.
- NBits, ParityEn and ParityOdd are captured at IDLE→START. Changes mid-frame have no effect.
- RxData = shift register >> (DW-NBits).
- Frames with FrameErr or ParityErr are still delivered with the flag set.
- Output handshake:
  - RxValid rises with a new word and stays high, with RxData/FrameErr/ParityErr stable, until a cycle with RxReady=1.
  - If a frame completes while RxValid=1 and RxReady=0 in that cycle, the new word is discarded, the held word is kept, and Overrun is set.
  - If RxReady=1 in the same cycle a frame completes, the new word replaces the old one and no overrun occurs.
- Overrun is sticky. It clears on the next accepted handshake.
- RxEn=0 in any non-IDLE state: go to IDLE next cycle and discard the partial frame. The output register is unaffected.

## Timing
- Reset values: RxData=0, RxValid=0, FrameErr=0, ParityErr=0, Overrun=0, Busy=0, FSM=IDLE, synchroniser=1.
- Start detect latency is 2 Clk (synchroniser) + 1 Clk (edge register).
- RxValid asserts 1 Clk after the Tick carrying the stop-bit third vote sample.
- RxValid deasserts 1 Clk after the cycle where RxValid & RxReady.
- Busy is high from the cycle after start detect until the cycle after the stop vote.
- Reset asserted mid-frame clears all state immediately (asynchronous). Reception resumes only on a fresh falling edge after release.
- Without Tick the FSM holds; only the synchroniser and edge register keep running.

## Test plan
- DW=8, OVERSAMPLE=16, NBits=8, parity off, line byte 0xA5 → RxValid 1 Clk after the stop vote, RxData=0xA5, FrameErr=0, ParityErr=0.
- NBits=7, ParityEn=1, ParityOdd=0, send 0x41 with parity bit 1 → RxData=0x41, ParityErr=1. Repeat with parity bit 0 → ParityErr=0.
- Rx low for 4 Ticks then high → no RxValid, Busy drops by mid-start, and the next valid frame 0x3C is received correctly.
- Send 0x55 with stop bit 0 → RxData=0x55, FrameErr=1. The FSM returns to IDLE and the next frame 0x0F is received correctly.
- Hold RxReady=0 and send 0x11 then 0x22 back-to-back → RxData stays 0x11 and Overrun=1. Raise RxReady → RxValid drops next cycle and Overrun clears.
- Pull Rst_n low during data bit 3 of a frame → all outputs return to reset values at once and no partial word appears. Drop RxEn mid-frame → the frame is aborted, with identical output behaviour.

Source files
------------

// File: rtl/uart_rx_param.sv
// UART receive engine: 2-flop synchroniser, majority-vote sampling around mid-bit,
// runtime data length / parity, and a single-word ready/valid holding register.
module uart_rx_param #(
  parameter int DW         = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          RxEn,
  input  logic          Tick,
  input  logic          Rx,
  input  logic [3:0]    NBits,
  input  logic          ParityEn,
  input  logic          ParityOdd,
  output logic [DW-1:0] RxData,
  output logic          RxValid,
  input  logic          RxReady,
  output logic          FrameErr,
  output logic          ParityErr,
  output logic          Overrun,
  output logic          Busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_MAX = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] SMP0    = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] SMP1    = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] SMP2    = CW'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic          rx_meta_q, rxs_q, rxs_prev_q;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          s0_q, s1_q;
  logic [3:0]    bit_idx_q, nbits_q;
  logic          par_en_q, par_odd_q, frame_perr_q;
  logic [DW-1:0] shift_q;
  logic [DW-1:0] data_q;
  logic          valid_q, ferr_q, perr_q, ovr_q, busy_q;

  logic          fall_d, wrap_d, vote_tick_d, vote_d, accept_d, frame_done_d;
  logic [CW-1:0] cnt_d;
  logic [3:0]    nbits_sel_d, shamt_d;

  assign fall_d       = rxs_prev_q & ~rxs_q;
  assign wrap_d       = Tick && (cnt_q == CNT_MAX);
  assign vote_tick_d  = Tick && (cnt_q == SMP2);
  assign vote_d       = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
  assign cnt_d        = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
  assign nbits_sel_d  = (NBits < 4'd5 || NBits > 4'(DW)) ? 4'(DW) : NBits;
  assign shamt_d      = 4'(DW) - nbits_q;
  assign accept_d     = valid_q & RxReady;
  assign frame_done_d = (state_q == S_STOP) && RxEn && vote_tick_d;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= Rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      s0_q         <= 1'b1;
      s1_q         <= 1'b1;
      bit_idx_q    <= '0;
      nbits_q      <= 4'(DW);
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      frame_perr_q <= 1'b0;
      shift_q      <= '0;
      busy_q       <= 1'b0;
    end else if (state_q != S_IDLE && !RxEn) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
    end else begin
      if (Tick && state_q != S_IDLE) begin
        cnt_q <= cnt_d;
        if (cnt_q == SMP0) s0_q <= rxs_q;
        if (cnt_q == SMP1) s1_q <= rxs_q;
      end
      case (state_q)
        S_IDLE: begin
          if (RxEn && fall_d) begin
            state_q      <= S_START;
            busy_q       <= 1'b1;
            cnt_q        <= '0;
            nbits_q      <= nbits_sel_d;
            par_en_q     <= ParityEn;
            par_odd_q    <= ParityOdd;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            frame_perr_q <= 1'b0;
          end
        end
        S_START: begin
          if (vote_tick_d && vote_d) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (wrap_d) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (vote_tick_d) shift_q <= {vote_d, shift_q[DW-1:1]};
          if (wrap_d) begin
            if (bit_idx_q == nbits_q - 4'd1) begin
              state_q   <= par_en_q ? S_PARITY : S_STOP;
              bit_idx_q <= '0;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end
        end
        S_PARITY: begin
          // Unreceived positions of shift_q are zero, so the full reduction is the data parity.
          if (vote_tick_d) frame_perr_q <= ((vote_d ^ (^shift_q)) != par_odd_q);
          if (wrap_d) state_q <= S_STOP;
        end
        S_STOP: begin
          if (vote_tick_d) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (frame_done_d) begin
      if (!valid_q || RxReady) begin
        data_q  <= shift_q >> shamt_d;
        valid_q <= 1'b1;
        ferr_q  <= ~vote_d;
        perr_q  <= frame_perr_q;
        ovr_q   <= accept_d ? 1'b0 : ovr_q;
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (accept_d) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign RxData    = data_q;
  assign RxValid   = valid_q;
  assign FrameErr  = ferr_q;
  assign ParityErr = perr_q;
  assign Overrun   = ovr_q;
  assign Busy      = busy_q;

endmodule
